// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the unified-memory port arbiter.
// Holds the FSM state codes, the request-source codes and the full-word byte mask.
// Pure constants: no logic, no timing.
package rv32_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam logic [3:0] MASK_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D); data wins, a starvation guard forces fetch.
// Latency: request seen in IDLE -> o_mem_req next cycle; ready pulses the cycle after i_mem_rvalid (min 3 cycles).
// Backpressure: requesters hold valid until their ready pulse; o_mem_req and its fields are held until i_mem_gnt.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_imem_valid,
  input  logic [ADDR_W-1:0] i_imem_addr,
  output logic              o_imem_ready,
  output logic [XLEN-1:0]   o_imem_rdata,
  input  logic              i_dmem_valid,
  input  logic              i_dmem_wen,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic [XLEN-1:0]   i_dmem_wdata,
  input  logic [3:0]        i_dmem_mask,
  output logic              o_dmem_ready,
  output logic [XLEN-1:0]   o_dmem_rdata,
  output logic              o_mem_req,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              src;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_wen;
  logic [XLEN-1:0]   lat_wdata;
  logic [3:0]        lat_mask;
  logic              abandoned;
  logic [XLEN-1:0]   imem_rdata_q;
  logic [XLEN-1:0]   dmem_rdata_q;

  logic              grant_d;
  logic              grant_i;
  logic              src_valid;
  logic [ADDR_W-1:0] src_addr;
  logic              drop;

  // Grant selection and detection of a requester that has walked away from its transaction
  always_comb begin
    grant_d   = i_dmem_valid && (!i_imem_valid || (starve_cnt < LIMIT));
    grant_i   = i_imem_valid && !grant_d;
    src_valid = (src == SRC_D) ? i_dmem_valid : i_imem_valid;
    src_addr  = (src == SRC_D) ? i_dmem_addr  : i_imem_addr;
    // Once abandoned, a transaction stays abandoned even if the requester comes back
    drop      = abandoned || !src_valid || (src_addr != lat_addr);
  end

  // Transaction FSM: latch the winner in IDLE, run it to completion, always finish through RESP
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      src       <= SRC_I;
      lat_addr  <= '0;
      lat_wen   <= 1'b0;
      lat_wdata <= '0;
      lat_mask  <= '0;
      abandoned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d || grant_i) begin
            state     <= ST_REQ;
            abandoned <= 1'b0;
            if (grant_d) begin
              src       <= SRC_D;
              lat_addr  <= i_dmem_addr;
              lat_wen   <= i_dmem_wen;
              lat_wdata <= i_dmem_wdata;
              lat_mask  <= i_dmem_mask;
            end else begin
              src       <= SRC_I;
              lat_addr  <= i_imem_addr;
              lat_wen   <= 1'b0;
              lat_wdata <= '0;
              lat_mask  <= MASK_WORD;
            end
          end
        end
        ST_REQ: begin
          abandoned <= drop;
          if (i_mem_gnt) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          abandoned <= drop;
          if (i_mem_rvalid) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Starvation counter: counts data grants that overtook a pending fetch
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && (grant_d || grant_i)) begin
      if (grant_d && i_imem_valid) begin
        starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Response capture into the owning source's data register; abandoned responses are discarded
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else if (state == ST_WAIT && i_mem_rvalid && !drop) begin
      if (src == SRC_D) begin
        dmem_rdata_q <= i_mem_rdata;
      end else begin
        imem_rdata_q <= i_mem_rdata;
      end
    end
  end

  assign o_mem_req    = (state == ST_REQ);
  assign o_mem_wen    = o_mem_req ? lat_wen   : 1'b0;
  assign o_mem_addr   = o_mem_req ? lat_addr  : '0;
  assign o_mem_wdata  = o_mem_req ? lat_wdata : '0;
  assign o_mem_mask   = o_mem_req ? lat_mask  : 4'h0;

  assign o_imem_ready = (state == ST_RESP) && (src == SRC_I) && !drop;
  assign o_dmem_ready = (state == ST_RESP) && (src == SRC_D) && !drop;
  assign o_imem_rdata = imem_rdata_q;
  assign o_dmem_rdata = dmem_rdata_q;
  assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized concurrent fetch/load/store traffic.
// Expected responses are queued at issue time and checked by an independent monitor on each ready pulse.
// A behavioural memory answers the downstream port with fixed or random grant/response delays.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_imem_valid;
  logic [31:0] i_imem_addr;
  logic        o_imem_ready;
  logic [31:0] o_imem_rdata;
  logic        i_dmem_valid;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic        o_dmem_ready;
  logic [31:0] o_dmem_rdata;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_imem_valid(i_imem_valid), .i_imem_addr(i_imem_addr),
    .o_imem_ready(o_imem_ready), .o_imem_rdata(o_imem_rdata),
    .i_dmem_valid(i_dmem_valid), .i_dmem_wen(i_dmem_wen), .i_dmem_addr(i_dmem_addr),
    .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask),
    .o_dmem_ready(o_dmem_ready), .o_dmem_rdata(o_dmem_rdata),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [7:0]  grant_log[$];
  logic [7:0]  ready_log[$];

  // memory-side controls
  bit mem_auto = 1'b1;
  bit mem_rand = 1'b0;
  int gd_fix   = 0;
  int rd_fix   = 0;

  logic [7:0]  mem_b[int];
  logic [31:0] ref_w[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // initial memory image: a recognisable instruction at 0x100, a hash elsewhere
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] store_ack(input logic [31:0] a);
    return {16'h5A0D, a[15:0]};
  endfunction

  // byte-addressed memory seen by the downstream port
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] iw;
    iw = init_word(a);
    for (int k = 0; k < 4; k++) begin
      if (mem_b.exists(int'(a) + k)) w[8*k +: 8] = mem_b[int'(a) + k];
      else                           w[8*k +: 8] = iw[8*k +: 8];
    end
    return w;
  endfunction

  // reference model: word view of data memory, stores merged with an expanded byte mask
  function automatic logic [31:0] ref_load(input logic [31:0] a);
    if (ref_w.exists(int'(a))) return ref_w[int'(a)];
    return init_word(a);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    ref_w[int'(a)] = (ref_load(a) & ~bm) | (wd & bm);
  endtask

  // downstream memory responder
  initial begin
    logic [31:0] a, wd;
    logic        we;
    logic [3:0]  m;
    int          gd, rd;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (mem_auto && o_mem_req) begin
        a = o_mem_addr; we = o_mem_wen; wd = o_mem_wdata; m = o_mem_mask;
        gd = mem_rand ? int'($urandom_range(3)) : gd_fix;
        rd = mem_rand ? int'($urandom_range(3)) : rd_fix;
        for (int k = 0; k < gd; k++) begin
          @(negedge i_clk);
          check("req_held", 32'(o_mem_req), 32'd1);
          check("req_addr_stable", o_mem_addr, a);
          check("req_wdata_stable", o_mem_wdata, wd);
          check("req_ctl_stable", 32'({o_mem_wen, o_mem_mask}), 32'({we, m}));
        end
        i_mem_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b0;
        if (we) begin
          for (int k = 0; k < 4; k++) if (m[k]) mem_b[int'(a) + k] = wd[8*k +: 8];
        end
        for (int k = 0; k < rd; k++) begin @(posedge i_clk); #1; end
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = we ? store_ack(a) : mem_rd(a);
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = $urandom;
      end
    end
  end

  // monitor: ready scoreboard, output hygiene, arbitration-rule model
  initial begin
    logic        prev_iv, prev_dv, prev_req, prev_dwen, exp_is_d, act_is_d;
    logic [31:0] prev_iaddr, prev_daddr, prev_dwdata;
    logic [3:0]  prev_dmask;
    int          streak;
    prev_iv = 0; prev_dv = 0; prev_req = 0; prev_dwen = 0;
    prev_iaddr = 0; prev_daddr = 0; prev_dwdata = 0; prev_dmask = 0;
    streak = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        streak = 0;
      end else begin
        check("ready_exclusive", 32'(o_imem_ready & o_dmem_ready), 32'd0);
        if (!o_mem_req)
          check("idle_fields_zero", o_mem_addr | o_mem_wdata | 32'({o_mem_wen, o_mem_mask}), 32'd0);
        if (o_imem_ready) begin
          ready_log.push_back("I");
          check("imem_ready_expected", 32'(exp_i.size() != 0), 32'd1);
          if (exp_i.size() != 0) check("imem_rdata", o_imem_rdata, exp_i.pop_front());
        end
        if (o_dmem_ready) begin
          ready_log.push_back("D");
          check("dmem_ready_expected", 32'(exp_d.size() != 0), 32'd1);
          if (exp_d.size() != 0) check("dmem_rdata", o_dmem_rdata, exp_d.pop_front());
        end
        if (o_mem_req && !prev_req) begin
          check("req_has_requester", 32'(prev_iv | prev_dv), 32'd1);
          exp_is_d = prev_dv && (!prev_iv || streak < LIMIT);
          act_is_d = (o_mem_addr >= 32'h2000);
          grant_log.push_back(act_is_d ? 8'h44 : 8'h49);
          check("grant_src", 32'(act_is_d), 32'(exp_is_d));
          if (exp_is_d) begin
            check("req_d_addr", o_mem_addr, prev_daddr);
            check("req_d_ctl", 32'({o_mem_wen, o_mem_mask}), 32'({prev_dwen, prev_dmask}));
            if (prev_dwen) check("req_d_wdata", o_mem_wdata, prev_dwdata);
            streak = prev_iv ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
          end else begin
            check("req_i_addr", o_mem_addr, prev_iaddr);
            check("req_i_ctl", 32'({o_mem_wen, o_mem_mask}), 32'({1'b0, 4'hF}));
            streak = 0;
          end
        end
      end
      prev_iv = i_imem_valid; prev_dv = i_dmem_valid; prev_req = o_mem_req;
      prev_iaddr = i_imem_addr; prev_daddr = i_dmem_addr; prev_dwen = i_dmem_wen;
      prev_dwdata = i_dmem_wdata; prev_dmask = i_dmem_mask;
    end
  end

  task automatic issue_i(input logic [31:0] a, output int lat);
    int st, n;
    @(posedge i_clk); #1;
    i_imem_valid = 1'b1; i_imem_addr = a;
    exp_i.push_back(init_word(a));
    st = cyc; n = 0;
    do begin @(negedge i_clk); n++; end while (!o_imem_ready && n < 400);
    check("imem_timeout", 32'(o_imem_ready), 32'd1);
    lat = cyc - st;
  endtask

  task automatic release_i();
    @(posedge i_clk); #1;
    i_imem_valid = 1'b0;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] m, output int lat);
    int st, n;
    @(posedge i_clk); #1;
    i_dmem_valid = 1'b1; i_dmem_addr = a; i_dmem_wen = we; i_dmem_wdata = wd; i_dmem_mask = m;
    if (we) begin
      exp_d.push_back(store_ack(a));
      ref_store(a, wd, m);
    end else begin
      exp_d.push_back(ref_load(a));
    end
    st = cyc; n = 0;
    do begin @(negedge i_clk); n++; end while (!o_dmem_ready && n < 400);
    check("dmem_timeout", 32'(o_dmem_ready), 32'd1);
    lat = cyc - st;
  endtask

  task automatic release_d();
    @(posedge i_clk); #1;
    i_dmem_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2;
    i_rst_n = 1'b0;
    i_imem_valid = 0; i_imem_addr = 0;
    i_dmem_valid = 0; i_dmem_wen = 0; i_dmem_addr = 0; i_dmem_wdata = 0; i_dmem_mask = 0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ctl", 32'({o_busy, o_mem_req, o_imem_ready, o_dmem_ready, o_mem_wen, o_mem_mask}), 32'd0);
    check("rst_imem_rdata", o_imem_rdata, 32'd0);
    check("rst_dmem_rdata", o_dmem_rdata, 32'd0);
    check("rst_mem_addr", o_mem_addr | o_mem_wdata, 32'd0);

    // 1: single fetch, 1-cycle memory
    gd_fix = 0; rd_fix = 0;
    issue_i(32'h100, lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_rdata", o_imem_rdata, 32'h00500093);
    release_i();

    // 2: simultaneous requests, data first
    ready_log.delete();
    fork
      begin issue_d(32'h2000, 1'b0, 32'h0, 4'hF, lat); release_d(); end
      begin issue_i(32'h104, lat2); release_i(); end
    join
    check("t2_ready_count", 32'(ready_log.size()), 32'd2);
    check("t2_order", 32'({ready_log[0], ready_log[1]}), 32'({8'h44, 8'h49}));

    // 3: starvation guard
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) issue_d(32'h2000 + 32'(4 * k), 1'b0, 32'h0, 4'hF, lat);
        release_d();
      end
      begin issue_i(32'h108, lat2); release_i(); end
    join
    check("t3_grant_count", 32'(grant_log.size()), 32'd7);
    check("t3_order_hi", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), "DDDD");
    check("t3_order_lo", 32'({grant_log[4], grant_log[5]}), 32'({8'h49, 8'h44}));

    // 4: partial store with a delayed grant, then read it back
    gd_fix = 3;
    issue_d(32'h3000, 1'b1, 32'hDEADBEEF, 4'b0011, lat);
    check("t4_store_latency", 32'(lat), 32'd6);
    release_d();
    gd_fix = 0;
    issue_d(32'h3000, 1'b0, 32'h0, 4'hF, lat);
    check("t4_readback", o_dmem_rdata, (init_word(32'h3000) & 32'hFFFF0000) | 32'h0000BEEF);
    release_d();

    // 5: fetch abandoned while waiting for the response
    rd_fix = 3;
    @(posedge i_clk); #1;
    i_imem_valid = 1'b1; i_imem_addr = 32'h200;
    repeat (2) @(posedge i_clk);
    #1 i_imem_valid = 1'b0;
    repeat (8) @(negedge i_clk);
    check("t5_idle", 32'(o_busy), 32'd0);
    check("t5_rdata_kept", o_imem_rdata, init_word(32'h108));
    rd_fix = 0;
    issue_i(32'h300, lat);
    check("t5_next_fetch_latency", 32'(lat), 32'd3);
    release_i();

    // 6: reset during WAIT, stale response afterwards
    mem_auto = 1'b0;
    @(posedge i_clk); #1;
    i_imem_valid = 1'b1; i_imem_addr = 32'h400;
    @(negedge i_clk);
    @(negedge i_clk);
    check("t6_req", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_mem_gnt = 1'b0;
    i_rst_n = 1'b0; i_imem_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("t6_rst_ctl", 32'({o_busy, o_mem_req, o_imem_ready, o_dmem_ready, o_mem_wen, o_mem_mask}), 32'd0);
    check("t6_rst_rdata", o_imem_rdata | o_dmem_rdata, 32'd0);
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("t6_stale_ignored", 32'(o_busy), 32'd0);
    check("t6_stale_rdata", o_imem_rdata, 32'd0);
    mem_auto = 1'b1;
    issue_i(32'h300, lat);
    check("t6_recover_rdata", o_imem_rdata, init_word(32'h300));
    release_i();

    // randomized concurrent traffic with random memory timing
    mem_rand = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          issue_i(32'($urandom_range(1023)) << 2, lat);
          if ($urandom_range(2) == 0) begin
            release_i();
            repeat ($urandom_range(3)) @(posedge i_clk);
          end
        end
        release_i();
      end
      begin
        for (int k = 0; k < 40; k++) begin
          issue_d(32'h2000 + (32'($urandom_range(15)) << 2), 1'($urandom_range(1)),
                  $urandom, 4'($urandom_range(15)), lat2);
          if ($urandom_range(2) == 0) begin
            release_d();
            repeat ($urandom_range(3)) @(posedge i_clk);
          end
        end
        release_d();
      end
    join
    mem_rand = 1'b0;

    repeat (10) @(negedge i_clk);
    check("final_exp_i_empty", 32'(exp_i.size()), 32'd0);
    check("final_exp_d_empty", 32'(exp_d.size()), 32'd0);
    check("final_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
